// File: rtl/execute_stage.sv
// Execute stage: one-cycle add/sub/and, 4-cycle shift-add multiply,
// registered valid/ready result towards writeback.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  opcode,
    input  logic [31:0] read_reg_1,
    input  logic [31:0] read_reg_2,
    input  logic [4:0]  write_dest,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] acc, acc_n;
    logic [31:0] a_q, a_n, b_q, b_n;
    logic [4:0]  dest_q, dest_n;
    logic [7:0]  b_byte;
    logic [31:0] prod, partial, alu_res;
    logic        out_free, accept, load;
    logic [4:0]  load_addr;
    logic [31:0] load_data;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        b_byte = b_q[7:0];
        case (cnt)
            2'd0: b_byte = b_q[7:0];
            2'd1: b_byte = b_q[15:8];
            2'd2: b_byte = b_q[23:16];
            2'd3: b_byte = b_q[31:24];
            default: b_byte = b_q[7:0];
        endcase
    end

    // Truncating before the shift gives the same low 32 bits.
    assign prod    = a_q * {24'd0, b_byte};
    assign partial = prod << {cnt, 3'b000};

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = read_reg_1 + read_reg_2;
            OP_SUB:  alu_res = read_reg_1 - read_reg_2;
            OP_AND:  alu_res = read_reg_1 & read_reg_2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        acc_n     = acc;
        a_n       = a_q;
        b_n       = b_q;
        dest_n    = dest_q;
        load      = 1'b0;
        load_addr = dest_q;
        load_data = acc;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        a_n     = read_reg_1;
                        b_n     = read_reg_2;
                        dest_n  = write_dest;
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = MUL;
                    end else begin
                        load      = 1'b1;
                        load_addr = write_dest;
                        load_data = alu_res;
                    end
                end
            end
            MUL: begin
                if (cnt != 2'd3) begin
                    acc_n = acc + partial;
                    cnt_n = cnt + 2'd1;
                end else if (out_free) begin
                    load      = 1'b1;
                    load_data = acc + partial;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else begin
                    acc_n   = acc + partial;
                    cnt_n   = '0;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_free) begin
                    load    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dest_q     <= '0;
            out_valid  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            a_q    <= a_n;
            b_q    <= b_n;
            dest_q <= dest_n;
            // A load in the same cycle as a pop keeps out_valid high.
            if (load) begin
                out_valid  <= 1'b1;
                write_addr <= load_addr;
                write_data <= load_data;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the add pipeline, sitting between decode and writeback. It takes decoded operands, the opcode and the destination register index through a valid/ready handshake. It computes the result and presents `write_addr`/`write_data` to the writeback stage through a registered valid/ready output. Add, sub and and complete in one cycle; multiply is a 4-cycle iterative shift-add that stalls the input while it runs.

## Interface
Parameters: none (32-bit datapath, 5-bit register index).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  decode presents an operation
- `in_ready`  out  1  stage accepts the operation this cycle
- `opcode`  in  2  00 add, 01 sub, 10 and, 11 mul
- `read_reg_1`  in  32  operand A
- `read_reg_2`  in  32  operand B
- `write_dest`  in  5  destination register index
- `out_valid`  out  1  `write_addr`/`write_data` hold a result
- `out_ready`  in  1  writeback consumes the result this cycle
- `write_addr`  out  5  destination index to writeback
- `write_data`  out  32  result to writeback
- `busy`  out  1  multiply in progress or result pending (state != IDLE)

## Operation
- FSM states:
  - IDLE: accepting.
  - MUL: iterating, `cnt` 0..3.
  - DONE: multiply finished, output register occupied.
- `out_free = !out_valid || out_ready`.
- `in_ready = (state == IDLE) && out_free`. Purely combinational; no dependence on `in_valid`.
- Accept = `in_valid && in_ready`.
- Accept with opcode 00/01/10:
  - Output register loads `write_addr = write_dest` and `write_data` = A+B, A−B or A&B.
  - `out_valid` = 1.
  - State stays IDLE.
- Accept with opcode 11:
  - Latch A, B and dest; `acc` = 0; `cnt` = 0; state → MUL.
- MUL, each cycle:
  - `partial = (A * B[8*cnt+7 : 8*cnt]) << (8*cnt)`, truncated to 32 bits.
  - If `cnt < 3`: `acc += partial`, `cnt++`.
  - If `cnt == 3` and `out_free`: output register loads `acc + partial` and the latched dest; `out_valid` = 1; state → IDLE.
  - If `cnt == 3` and not `out_free`: `acc += partial`; state → DONE.
- DONE: when `out_free`, load `acc` and dest into the output register, set `out_valid`, state → IDLE.
- Output pop: when `out_valid && out_ready` and nothing loads this cycle, `out_valid` → 0. Pop and load in the same cycle: the load wins and `out_valid` stays 1.
- While `out_valid && !out_ready`, `write_addr`/`write_data` do not change.
- Arithmetic:
  - Add and sub wrap modulo 2^32, with no flags.
  - Multiply returns the low 32 bits of the unsigned product.
  - Dest 0 is passed through unchanged; writeback decides what to do with it.

## Timing
- Reset, and every output after it: state IDLE, `cnt` 0, `acc` 0, `out_valid` 0, `write_addr` 0, `write_data` 0, `busy` 0, `in_ready` 1.
- Reset mid-multiply or with a result pending discards everything; no result is emitted.
- ALU latency: 1 cycle. Accept at edge N gives `out_valid` after edge N.
- ALU throughput: 1 op per cycle while `out_ready` is held high.
- Multiply, with `out_ready` high:
  - Accept at edge N; MUL iterations at edges N+1..N+4.
  - `out_valid` after edge N+4 (latency 4).
  - `in_ready` is 0 during cycles N+1..N+4; next accept possible at edge N+5.
- Multiply under backpressure: waits in DONE; the result loads on the first edge where `out_free`.
- `in_valid` while `in_ready` is 0: ignored; decode must hold its operation.

## Test plan
- Reset, then add A=7 B=5 dest=3 → next cycle `out_valid`=1, `write_addr`=3, `write_data`=12; `out_valid` drops after the pop.
- Sub A=5 B=7 → `write_data`=0xFFFFFFFE. And A=0xF0F0F0F0 B=0xFF00FF00 → 0xF000F000.
- Mul 0x12345678×9 dest=7 → `out_valid` exactly 4 cycles after accept, data 0xA3D70A38, `in_ready`=0 throughout. Mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- `out_ready`=0, issue add 1+1 then add 2+2 → output holds 2/addr stable; `in_ready`=0 for the second op. Raise `out_ready` → 2 is popped, then 4 is accepted, then 4 appears.
- `out_ready`=1, three back-to-back ALU ops on consecutive cycles → three results on consecutive cycles, in order.
- Assert `rst` two cycles into a mul → no `out_valid`, `busy`=0, `in_ready`=1 the cycle after; a following add 3+4 returns 7 normally.
